axis_fifo_rd_gate: RTL
======================

# axis_fifo_rd_gate

Parametrised read-release controller for the AXI-Stream TX FIFO feeding the GT transmit path. It tracks FIFO occupancy and stored-frame count from the write- and read-side handshakes. It releases FIFO reads in either cut-through (fill-threshold) or store-and-forward mode, and ends each read burst on the accepted last beat. It pauses mid-frame while the GT transmitter is inactive and flags FIFO overflow/underrun.

## Interface
Parameters:
- DEPTH, 512: FIFO depth in words.
- CNT_W, $clog2(DEPTH+1): fill counter width.
- START_THRESH, 64: cut-through start level in words, 1..DEPTH.
- MODE, 0: 0 = cut-through, 1 = store-and-forward.
- MAX_FRAMES, 16: frame counter saturation value.
- FRM_W, $clog2(MAX_FRAMES+1): frame counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid / wr_ready / wr_last  in  1 each  FIFO write-side AXIS handshake, observed.
- rd_valid / rd_ready / rd_last  in  1 each  FIFO read-side AXIS handshake, observed.
- GT_Tx_active  in  1  GT transmitter ready for data.
- fifo_rd_enable  out  1  registered read release to the FIFO.
- fill_level  out  CNT_W  words currently stored.
- frames_stored  out  FRM_W  complete frames stored.
- gate_state  out  2  00 IDLE, 01 STREAM, 10 HOLD.
- overflow_err  out  1  sticky overflow flag.
- underrun_err  out  1  sticky underrun flag.

## Operation
- Handshakes: wr_hs = wr_valid & wr_ready; rd_hs = rd_valid & rd_ready.
- fill_level: +1 on wr_hs only, −1 on rd_hs only, unchanged on both or neither.
  - Saturates at DEPTH and 0.
  - wr_hs alone at DEPTH sets overflow_err; rd_hs alone at 0 sets underrun_err.
  - Flags clear only on rst.
- frames_stored:
  - +1 on wr_hs&wr_last, −1 on rd_hs&rd_last, unchanged if both.
  - Saturates at MAX_FRAMES and 0; no error flag.
- Start condition, evaluated on registered counter values:
  - MODE 0: fill_level ≥ START_THRESH, or frames_stored > 0 (short frames never stall).
  - MODE 1: frames_stored > 0.
- State machine:
  - IDLE → STREAM: GT_Tx_active & start condition.
  - STREAM → IDLE: rd_hs & rd_last (handshake-qualified, so back-to-back frames are never missed). Takes priority over the HOLD transition.
  - STREAM → HOLD: !GT_Tx_active and no last beat accepted this cycle.
  - HOLD → STREAM: GT_Tx_active. HOLD → IDLE: rd_hs & rd_last (late beat in flight).
- fifo_rd_enable = 1 only in STREAM; registered, no combinational path from inputs.
- After STREAM → IDLE, stay in IDLE at least one cycle (one-cycle inter-burst gap), even if the start condition already holds.

## Timing
- Reset: state IDLE, fifo_rd_enable 0, fill_level 0, frames_stored 0, both error flags 0. Takes effect at the first rising edge with rst = 1.
- rst mid-burst: fifo_rd_enable low the cycle after the reset edge. Counters are cleared regardless of actual FIFO contents; the FIFO must be reset together with this block.
- Counter latency: a handshake at edge n is reflected in fill_level/frames_stored after edge n.
- Start latency:
  - The start condition holds on counters after edge n and GT_Tx_active = 1 at edge n+1.
  - fifo_rd_enable goes high after edge n+1.
  - A write crossing the threshold at edge n therefore gives rd enable 2 cycles later.
- Stop latency: last-beat rd_hs at edge k → fifo_rd_enable low after edge k; no beat beyond rd_last is released.
- HOLD entry/exit: one cycle after GT_Tx_active changes.
- Earliest re-start after a burst: fifo_rd_enable high again after edge k+2.

## Test plan
- MODE 0, START_THRESH=64, GT active:
  - Write 63 words without last → fifo_rd_enable stays 0.
  - 64th write at edge n → fifo_rd_enable 1 after edge n+1.
  - Read beats with rd_last on beat 100 → enable 0 right after that beat, fill_level = 0.
- MODE 0, GT active: write a 10-word frame with last → frames_stored = 1, enable rises 2 cycles after the last write despite fill 10 < 64.
- MODE 1: write 500 words without last → enable stays 0. Then the last word → enable 1 two cycles later; fill_level = 501.
- GT_Tx_active drops mid-burst for 5 cycles → gate_state 10, enable 0 for 5 cycles, fill_level frozen. Then STREAM resumes; on rd_last, frames_stored decrements.
- Boundary cases:
  - Simultaneous wr_hs and rd_hs → fill unchanged.
  - 513 writes with DEPTH=512 → fill_level holds 512, overflow_err = 1.
  - rd_hs at fill 0 → underrun_err = 1.
  - rst asserted mid-STREAM → all outputs return to reset values after the reset edge.
- Back-to-back frames in FIFO, MODE 1:
  - First burst ends on rd_last at edge k → IDLE for exactly one cycle, enable high again after edge k+2.
  - frames_stored decrements by 1 per burst.

Source files
------------

// File: rtl/axis_fifo_rd_gate.sv
// axis_fifo_rd_gate
// Read-release controller for the AXI-Stream TX FIFO in front of the GT
// transmitter. It shadows FIFO occupancy and the stored-frame count from the
// observed write/read handshakes. It releases reads in cut-through or
// store-and-forward mode, pauses while the GT is not ready, and ends each
// burst on the accepted last beat.
module axis_fifo_rd_gate #(
  parameter int DEPTH        = 512,
  parameter int CNT_W        = $clog2(DEPTH + 1),
  parameter int START_THRESH = 64,
  parameter int MODE         = 0,
  parameter int MAX_FRAMES   = 16,
  parameter int FRM_W        = $clog2(MAX_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic             wr_ready,
  input  logic             wr_last,
  input  logic             rd_valid,
  input  logic             rd_ready,
  input  logic             rd_last,
  input  logic             GT_Tx_active,
  output logic             fifo_rd_enable,
  output logic [CNT_W-1:0] fill_level,
  output logic [FRM_W-1:0] frames_stored,
  output logic [1:0]       gate_state,
  output logic             overflow_err,
  output logic             underrun_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_HOLD   = 2'b10
  } gate_state_t;

  localparam logic [CNT_W-1:0] FILL_MAX   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FILL_START = CNT_W'(START_THRESH);
  localparam logic [FRM_W-1:0] FRM_MAX    = FRM_W'(MAX_FRAMES);

  logic wr_hs;
  logic rd_hs;
  logic wr_eof;
  logic rd_eof;
  logic start_cond;

  gate_state_t      state_q;
  gate_state_t      state_d;
  logic             gap_q;
  logic             gap_d;
  logic             rd_en_q;
  logic [CNT_W-1:0] fill_q;
  logic [FRM_W-1:0] frames_q;
  logic             ovf_q;
  logic             unr_q;

  assign wr_hs  = wr_valid & wr_ready;
  assign rd_hs  = rd_valid & rd_ready;
  assign wr_eof = wr_hs & wr_last;
  assign rd_eof = rd_hs & rd_last;

  // Word occupancy tracking, saturating at both ends; out-of-range moves raise sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
      ovf_q  <= 1'b0;
      unr_q  <= 1'b0;
    end else if (wr_hs && !rd_hs) begin
      if (fill_q == FILL_MAX) begin
        ovf_q <= 1'b1;
      end else begin
        fill_q <= fill_q + CNT_W'(1);
      end
    end else if (rd_hs && !wr_hs) begin
      if (fill_q == '0) begin
        unr_q <= 1'b1;
      end else begin
        fill_q <= fill_q - CNT_W'(1);
      end
    end
  end

  // Complete-frame count, saturating silently at both ends
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
    end else if (wr_eof && !rd_eof) begin
      if (frames_q != FRM_MAX) begin
        frames_q <= frames_q + FRM_W'(1);
      end
    end else if (rd_eof && !wr_eof) begin
      if (frames_q != '0) begin
        frames_q <= frames_q - FRM_W'(1);
      end
    end
  end

  // Start condition from registered counters; a whole stored frame always qualifies
  always_comb begin
    start_cond = (frames_q != '0);
    if ((MODE == 0) && (fill_q >= FILL_START)) begin
      start_cond = 1'b1;
    end
  end

  // Gate FSM next state; gap_d forces one blocked IDLE cycle after every burst
  always_comb begin
    state_d = state_q;
    gap_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!gap_q && GT_Tx_active && start_cond) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (rd_eof) begin
          state_d = ST_IDLE;
          gap_d   = 1'b1;
        end else if (!GT_Tx_active) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rd_eof) begin
          state_d = ST_IDLE;
          gap_d   = 1'b1;
        end else if (GT_Tx_active) begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register plus registered read release derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q   <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rd_en_q <= (state_d == ST_STREAM);
    end
  end

  assign fifo_rd_enable = rd_en_q;
  assign fill_level     = fill_q;
  assign frames_stored  = frames_q;
  assign gate_state     = state_q;
  assign overflow_err   = ovf_q;
  assign underrun_err   = unr_q;

endmodule
